// File: rtl/trap_detector_pkg.sv
// Shared constants and state type for the simulation-exit trap detector.
// The ebreak encoding and the a0 index describe the halt convention that the trap sink expects.
package trap_pkg;

    localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;
    localparam logic [4:0]  A0_IDX       = 5'd10;
    localparam logic [63:0] TIMEOUT_CODE = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        RUN,
        EXIT,
        DONE
    } state_t;

    function automatic logic is_ebreak(input logic valid, input logic [31:0] inst_word);
        return valid && (inst_word == EBREAK_INST);
    endfunction

endpackage

// File: rtl/trap_detector_if.sv
// Commit stream from the core's writeback stage into the trap detector.
interface trap_detector_if;

    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [31:0] commit_inst;
    logic        commit_wen;
    logic [4:0]  commit_rd;
    logic [63:0] commit_wdata;

    modport master (
        output commit_valid, commit_pc, commit_inst,
        output commit_wen, commit_rd, commit_wdata
    );

    modport slave (
        input commit_valid, commit_pc, commit_inst,
        input commit_wen, commit_rd, commit_wdata
    );

endinterface

// File: rtl/trap_detector_commit_watchdog.sv
// Idle-cycle watchdog: expires when WDOG_CYCLES consecutive enabled cycles pass without a kick.
// WDOG_CYCLES = 0 disables it entirely.
module commit_watchdog #(
    parameter int WDOG_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int LIMIT = (WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0;
    localparam int CW    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);
    localparam bit ENABLED = (WDOG_CYCLES > 0);

    logic [CW-1:0] idle_count;

    // Saturating at LIMIT keeps the disabled configuration from ever wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_count <= '0;
        end else if (!enable || kick) begin
            idle_count <= '0;
        end else if (idle_count != LIMIT_V) begin
            idle_count <= idle_count + CW'(1);
        end
    end

    assign expired = ENABLED && enable && !kick && (idle_count == LIMIT_V);

endmodule

// File: rtl/trap_detector.sv
// Producer of the simulation exit bundle: detects the ebreak halt, shadows a0,
// forces a bad-trap exit on a commit hang, and counts cycles/instret while running.
module trap_detector
    import trap_pkg::*;
#(
    parameter int WDOG_CYCLES = 100000,
    parameter int CNT_W       = 64
) (
    input  logic              clock,
    input  logic              reset,
    trap_detector_if.slave    commit,
    output logic              exit,
    output logic [63:0]       pc,
    output logic [63:0]       a0,
    output logic [31:0]       inst,
    output logic              halted,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    state_t      state;
    logic [63:0] shadow_a0;
    logic [63:0] last_pc;
    logic [31:0] last_inst;
    logic        in_run;
    logic        wdog_expired;

    assign in_run = (state == RUN);

    commit_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .enable (in_run),
        .kick   (commit.commit_valid),
        .expired(wdog_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            exit        <= 1'b0;
            pc          <= '0;
            a0          <= '0;
            inst        <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            shadow_a0   <= '0;
            last_pc     <= '0;
            last_inst   <= '0;
        end else begin
            exit <= 1'b0;
            case (state)
                RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (commit.commit_valid) begin
                        instret_cnt <= instret_cnt + CNT_W'(1);
                        last_pc     <= commit.commit_pc;
                        last_inst   <= commit.commit_inst;
                        if (commit.commit_wen && commit.commit_rd == A0_IDX) begin
                            shadow_a0 <= commit.commit_wdata;
                        end
                    end
                    // ebreak itself never writes rd, so the pre-edge shadow is the exit code.
                    if (is_ebreak(commit.commit_valid, commit.commit_inst)) begin
                        state   <= EXIT;
                        exit    <= 1'b1;
                        halted  <= 1'b1;
                        pc      <= commit.commit_pc;
                        inst    <= commit.commit_inst;
                        a0      <= shadow_a0;
                        timeout <= 1'b0;
                    end else if (wdog_expired) begin
                        state   <= EXIT;
                        exit    <= 1'b1;
                        halted  <= 1'b1;
                        pc      <= last_pc;
                        inst    <= last_inst;
                        a0      <= TIMEOUT_CODE;
                        timeout <= 1'b1;
                    end
                end
                EXIT: begin
                    state <= DONE;
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_detector.sv
// Self-checking bench for trap_detector: directed halt/watchdog scenarios plus randomized
// commit streams compared against an idle-run-length reference model.
module tb_trap_detector;
    import trap_pkg::*;

    localparam int WDOG = 16;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exit;
    logic [63:0] pc;
    logic [63:0] a0;
    logic [31:0] inst;
    logic        halted;
    logic        timeout;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    trap_detector_if bus();

    trap_detector #(
        .WDOG_CYCLES(WDOG),
        .CNT_W      (64)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .commit     (bus.slave),
        .exit       (exit),
        .pc         (pc),
        .a0         (a0),
        .inst       (inst),
        .halted     (halted),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    int          m_phase;
    int          m_idle;
    logic [63:0] m_shadow, m_last_pc, m_pc, m_a0, m_cyc, m_instret;
    logic [31:0] m_last_inst, m_inst;
    logic        m_timeout;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_phase = 0; m_idle = 0;
        m_shadow = '0; m_last_pc = '0; m_pc = '0; m_a0 = '0;
        m_cyc = '0; m_instret = '0; m_last_inst = '0; m_inst = '0; m_timeout = 1'b0;
    endtask

    // Phase 0 = running, 1 = exit pulse, 2 = done; timeout fires on the WDOG-th idle cycle in a row.
    task automatic modelStep(input logic v, input logic [63:0] p, input logic [31:0] i,
                             input logic w, input logic [4:0] rd, input logic [63:0] d);
        if (m_phase == 0) begin
            m_cyc = m_cyc + 1;
            if (v) begin
                m_instret = m_instret + 1;
                m_idle = 0;
                if (i == 32'h0010_0073) begin
                    m_pc = p; m_inst = i; m_a0 = m_shadow; m_timeout = 1'b0; m_phase = 1;
                end
                if (w && rd == 5'd10) m_shadow = d;
                m_last_pc = p; m_last_inst = i;
            end else begin
                m_idle = m_idle + 1;
                if (m_idle == WDOG) begin
                    m_pc = m_last_pc; m_inst = m_last_inst; m_a0 = ALL_ONES;
                    m_timeout = 1'b1; m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".exit"},    exit,        64'(m_phase == 1));
        checkOutput({tag, ".halted"},  halted,      64'(m_phase != 0));
        checkOutput({tag, ".pc"},      pc,          m_pc);
        checkOutput({tag, ".a0"},      a0,          m_a0);
        checkOutput({tag, ".inst"},    inst,        64'(m_inst));
        checkOutput({tag, ".timeout"}, timeout,     64'(m_timeout));
        checkOutput({tag, ".cycle"},   cycle_cnt,   m_cyc);
        checkOutput({tag, ".instret"}, instret_cnt, m_instret);
    endtask

    // Called with the clock low; returns at the following negedge.
    task automatic applyStimulus(input string tag, input logic v, input logic [63:0] p,
                                 input logic [31:0] i, input logic w, input logic [4:0] rd,
                                 input logic [63:0] d);
        bus.commit_valid = v; bus.commit_pc = p; bus.commit_inst = i;
        bus.commit_wen = w; bus.commit_rd = rd; bus.commit_wdata = d;
        @(posedge clock);
        modelStep(v, p, i, w, rd, d);
        #1;
        checkAll(tag);
        @(negedge clock);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        bus.commit_valid = 1'b0; bus.commit_pc = '0; bus.commit_inst = '0;
        bus.commit_wen = 1'b0; bus.commit_rd = '0; bus.commit_wdata = '0;
        #1;
        modelReset();
        checkAll("reset");
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic scenarioGoodTrap();
        applyStimulus("s1_addi", 1'b1, 64'h8000_0000, 32'h0000_0513, 1'b1, 5'd10, 64'd0);
        applyStimulus("s1_ebreak", 1'b1, 64'h8000_0004, EBREAK_INST, 1'b0, 5'd0, 64'd0);
        checkOutput("s1_exit", exit, 64'd1);
        checkOutput("s1_pc", pc, 64'h8000_0004);
        checkOutput("s1_inst", inst, 64'h0010_0073);
        checkOutput("s1_a0", a0, 64'd0);
        checkOutput("s1_timeout", timeout, 64'd0);
        checkOutput("s1_instret", instret_cnt, 64'd2);
        checkOutput("s1_cycle", cycle_cnt, 64'd2);
        idle("s1_after");
        checkOutput("s1_exit_once", exit, 64'd0);
        checkOutput("s1_halted", halted, 64'd1);
    endtask

    initial begin
        logic [63:0] snap_pc, snap_a0, snap_cyc, snap_ir;
        doReset();

        scenarioGoodTrap();

        doReset();
        applyStimulus("s2_li", 1'b1, 64'h8000_0100, 32'h02a0_0513, 1'b1, 5'd10, 64'h2A);
        applyStimulus("s2_ebreak", 1'b1, 64'h8000_0104, EBREAK_INST, 1'b0, 5'd0, 64'd0);
        checkOutput("s2_a0", a0, 64'h2A);
        checkOutput("s2_exit", exit, 64'd1);
        for (int k = 0; k < 4; k++) idle("s2_hold");
        checkOutput("s2_halted", halted, 64'd1);

        doReset();
        applyStimulus("s3_commit", 1'b1, 64'h8000_0010, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        for (int k = 0; k < WDOG - 1; k++) idle("s3_idle");
        checkOutput("s3_no_early_exit", exit, 64'd0);
        idle("s3_expire");
        checkOutput("s3_exit", exit, 64'd1);
        checkOutput("s3_pc", pc, 64'h8000_0010);
        checkOutput("s3_a0", a0, ALL_ONES);
        checkOutput("s3_timeout", timeout, 64'd1);

        doReset();
        applyStimulus("s4_commit", 1'b1, 64'h8000_0200, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        for (int k = 0; k < WDOG - 1; k++) idle("s4_idle");
        applyStimulus("s4_kick", 1'b1, 64'h8000_0204, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
        checkOutput("s4_no_exit", exit, 64'd0);
        checkOutput("s4_running", halted, 64'd0);
        applyStimulus("s4_write", 1'b1, 64'h8000_0208, 32'h0550_0513, 1'b1, 5'd10, 64'h55);
        applyStimulus("s4_x0", 1'b1, 64'h8000_020C, 32'h0770_0013, 1'b1, 5'd0, 64'h77);
        applyStimulus("s4_ebreak", 1'b1, 64'h8000_0210, EBREAK_INST, 1'b0, 5'd0, 64'd0);
        checkOutput("s4_a0", a0, 64'h55);
        checkOutput("s4_timeout", timeout, 64'd0);

        idle("s5_done");
        snap_pc = pc; snap_a0 = a0; snap_cyc = cycle_cnt; snap_ir = instret_cnt;
        applyStimulus("s5_ebreak", 1'b1, 64'h9000_0000, EBREAK_INST, 1'b0, 5'd0, 64'd0);
        checkOutput("s5_no_exit", exit, 64'd0);
        applyStimulus("s5_write", 1'b1, 64'h9000_0004, 32'h0990_0513, 1'b1, 5'd10, 64'h99);
        checkOutput("s5_pc", pc, 64'h8000_0210);
        checkOutput("s5_a0", a0, 64'h55);
        checkOutput("s5_pc_frozen", pc, snap_pc);
        checkOutput("s5_a0_frozen", a0, snap_a0);
        checkOutput("s5_cyc_frozen", cycle_cnt, snap_cyc);
        checkOutput("s5_ir_frozen", instret_cnt, snap_ir);

        doReset();
        scenarioGoodTrap();

        for (int ep = 0; ep < 40; ep++) begin
            int pv;
            pv = int'($urandom_range(0, 100));
            doReset();
            for (int c = 0; c < 60; c++) begin
                logic        v, w;
                logic [31:0] iw;
                logic [4:0]  rd;
                v  = ($urandom_range(0, 99) < pv);
                iw = ($urandom_range(0, 29) == 0) ? EBREAK_INST : $urandom;
                rd = ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 31));
                w  = (iw == EBREAK_INST) ? 1'b0 : 1'($urandom_range(0, 1));
                applyStimulus("rand", v, {$urandom, $urandom}, iw, w, rd, {$urandom, $urandom});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
